// File: rtl/imem_param_if.sv
// rtl/imem_param_if.sv - fetch, response, program-load and status signals of the instruction memory
interface imem_param_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic                  fetch_valid;
   logic [ADDR_W-1:0]     fetch_addr;
   logic                  fetch_ready;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_data;
   logic                  rsp_err;
   logic                  rsp_ready;
   logic                  wr_en;
   logic [ADDR_W-1:0]     wr_addr;
   logic [DATA_W-1:0]     wr_data;
   logic [DATA_W/8-1:0]   wr_be;
   logic                  wr_ready;
   logic                  wr_err;
   logic                  init_busy;

   modport master (
      output fetch_valid, fetch_addr, rsp_ready, wr_en, wr_addr, wr_data, wr_be,
      input  fetch_ready, rsp_valid, rsp_data, rsp_err, wr_ready, wr_err, init_busy
   );

   modport slave (
      input  fetch_valid, fetch_addr, rsp_ready, wr_en, wr_addr, wr_data, wr_be,
      output fetch_ready, rsp_valid, rsp_data, rsp_err, wr_ready, wr_err, init_busy
   );
endinterface

// File: rtl/imem_param.sv
// rtl/imem_param.sv - parametrised instruction memory: byte-enable load port, registered fetch port, post-reset clear
module imem_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   imem_param_if.slave   bus
);
   localparam int BW    = DATA_W / 8;
   localparam int OFF_W = $clog2(BW);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int HI    = OFF_W + IDX_W;
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BW - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     cnt_q;
   logic                 rsp_valid_q;
   logic                 rsp_err_q;
   logic                 rsp_zero_q;
   logic                 wr_err_q;
   logic [DATA_W-1:0]    rd_word;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic                 mem_we;
   logic [IDX_W-1:0]     mem_widx;
   logic [DATA_W-1:0]    mem_wdata;
   logic [BW-1:0]        mem_wbe;

   logic                 run;
   logic                 fetch_acc;
   logic                 f_bad, wr_bad;
   logic [IDX_W-1:0]     f_idx, wr_idx;

   // Misaligned low bits or any bit above the word index make an address bad.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return ((a & OFF_MASK) != '0) || ((a >> HI) != '0);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
      return IDX_W'(a >> OFF_W);
   endfunction

   assign f_bad  = addr_bad(bus.fetch_addr);
   assign f_idx  = addr_idx(bus.fetch_addr);
   assign wr_bad = addr_bad(bus.wr_addr);
   assign wr_idx = addr_idx(bus.wr_addr);

   assign run       = (state_q == S_RUN);
   assign fetch_acc = bus.fetch_valid && bus.fetch_ready;

   assign bus.fetch_ready = run && (!rsp_valid_q || bus.rsp_ready);
   assign bus.wr_ready    = run;
   assign bus.init_busy   = (state_q == S_INIT);
   assign bus.wr_err      = wr_err_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_data    = rsp_zero_q ? '0 : rd_word;

   // The clearing sequencer owns the single write port while in INIT.
   always_comb begin
      state_d   = state_q;
      mem_we    = 1'b0;
      mem_widx  = wr_idx;
      mem_wdata = bus.wr_data;
      mem_wbe   = bus.wr_be;
      case (state_q)
         S_INIT: begin
            mem_we    = 1'b1;
            mem_widx  = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            mem_we = bus.wr_en && !wr_bad;
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_INIT;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_zero_q  <= 1'b1;
         wr_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_INIT) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (fetch_acc) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= f_bad;
            rsp_zero_q  <= f_bad;
         end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         if (run && bus.wr_en) begin
            wr_err_q <= wr_bad;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < BW; b++) begin
            if (mem_wbe[b]) begin
               mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   // Read-first: a same-edge write is not visible to this read.
   always_ff @(posedge clk) begin
      if (fetch_acc) begin
         rd_word <= mem[f_idx];
      end
   end
endmodule

// File: tb/tb_imem_param.sv
// tb/tb_imem_param.sv - self-checking bench for imem_param with vector table and response scoreboard
module tb_imem_param;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   imem_param_if #(.DATA_W(32), .ADDR_W(32)) bus ();
   imem_param #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
   } rsp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] exp_data;
      logic        exp_err;
      logic        exp_werr;
   } vec_t;

   rsp_t sb[$];
   vec_t vecs[15];
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = sb.pop_front();
            chk("rsp_data", bus.rsp_data, e.data);
            chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic wait_fetch_ready();
      int n = 0;
      @(negedge clk);
      while (!bus.fetch_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_ready_timeout", {31'd0, bus.fetch_ready}, 32'd1);
   endtask

   task automatic do_fetch(input logic [31:0] a, input logic [31:0] ed, input logic ee);
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = a;
      wait_fetch_ready();
      sb.push_back('{ed, ee});
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic exp_werr);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
      bus.wr_be   = be;
      @(negedge clk);
      chk("wr_ready", {31'd0, bus.wr_ready}, 32'd1);
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      chk("wr_err", {31'd0, bus.wr_err}, {31'd0, exp_werr});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", sb.size(), 32'd0);
   endtask

   task automatic count_init(input string name);
      int cnt = 0;
      chk({name, "_fetch_ready_start"}, {31'd0, bus.fetch_ready}, 32'd0);
      while (!bus.fetch_ready && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({name, "_cycles"}, cnt, 32'd64);
      chk({name, "_busy_done"}, {31'd0, bus.init_busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b0};
      vecs[1]  = '{1'b1, 32'h010, 32'h000000AA, 4'h1, 32'h0,        1'b0, 1'b0};
      vecs[2]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 32'h012, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0};
      vecs[4]  = '{1'b0, 32'h100, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0};
      vecs[5]  = '{1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0,        1'b0, 1'b1};
      vecs[6]  = '{1'b0, 32'h000, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1};
      vecs[7]  = '{1'b1, 32'h004, 32'hCAFEF00D, 4'hA, 32'h0,        1'b0, 1'b0};
      vecs[8]  = '{1'b0, 32'h004, 32'h0,        4'h0, 32'hCA00F000, 1'b0, 1'b0};
      vecs[9]  = '{1'b1, 32'h0FC, 32'h01020304, 4'hF, 32'h0,        1'b0, 1'b0};
      vecs[10] = '{1'b0, 32'h0FC, 32'h0,        4'h0, 32'h01020304, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 32'h101, 32'h0,        4'h0, 32'h0,        1'b1, 1'b0};
      vecs[12] = '{1'b1, 32'h022, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 1'b1};
      vecs[13] = '{1'b0, 32'h020, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1};
      vecs[14] = '{1'b1, 32'h020, 32'h55667788, 4'hF, 32'h0,        1'b0, 1'b0};

      bus.fetch_valid = 1'b0;
      bus.fetch_addr  = '0;
      bus.rsp_ready   = 1'b1;
      bus.wr_en       = 1'b0;
      bus.wr_addr     = '0;
      bus.wr_data     = '0;
      bus.wr_be       = '0;

      #3;
      chk("rst_init_busy", {31'd0, bus.init_busy}, 32'd1);
      chk("rst_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
      chk("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'h0);
      chk("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
      chk("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);

      // Fetch held pending at 0x0 through the whole clear.
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      count_init("init");
      sb.push_back('{32'h0, 1'b0});
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0;
      chk("first_rsp_latency", {31'd0, bus.rsp_valid}, 32'd1);
      drain();

      for (int i = 0; i < 15; i++) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].exp_werr);
         end else begin
            do_fetch(vecs[i].addr, vecs[i].exp_data, vecs[i].exp_err);
            chk("wr_err_hold", {31'd0, bus.wr_err}, {31'd0, vecs[i].exp_werr});
         end
      end
      drain();

      // Back-to-back fetches with a three-cycle consumer stall after the first response.
      fork
         begin
            logic [31:0] addrs [3];
            logic [31:0] datas [3];
            addrs[0] = 32'h0; addrs[1] = 32'h4;        addrs[2] = 32'h8;
            datas[0] = 32'h0; datas[1] = 32'hCA00F000; datas[2] = 32'h0;
            for (int k = 0; k < 3; k++) begin
               bus.fetch_valid = 1'b1;
               bus.fetch_addr  = addrs[k];
               wait_fetch_ready();
               sb.push_back('{datas[k], 1'b0});
               @(posedge clk); #1;
            end
            bus.fetch_valid = 1'b0;
         end
         begin
            int n = 0;
            logic [31:0] held;
            do begin
               @(posedge clk); #1;
               n++;
            end while (!bus.rsp_valid && n < 20);
            chk("bp_first_valid", {31'd0, bus.rsp_valid}, 32'd1);
            bus.rsp_ready = 1'b0;
            held = bus.rsp_data;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               chk("bp_valid_hold", {31'd0, bus.rsp_valid}, 32'd1);
               chk("bp_data_hold", bus.rsp_data, held);
               chk("bp_fetch_ready", {31'd0, bus.fetch_ready}, 32'd0);
            end
            @(posedge clk); #1;
            bus.rsp_ready = 1'b1;
         end
      join
      drain();

      // Same-edge write and fetch of 0x20: read-first.
      bus.wr_en       = 1'b1;
      bus.wr_addr     = 32'h20;
      bus.wr_data     = 32'h11223344;
      bus.wr_be       = 4'hF;
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = 32'h20;
      wait_fetch_ready();
      sb.push_back('{32'h55667788, 1'b0});
      @(posedge clk); #1;
      bus.wr_en       = 1'b0;
      bus.fetch_valid = 1'b0;
      do_fetch(32'h20, 32'h11223344, 1'b0);
      drain();

      // Reset while a response is held.
      bus.rsp_ready   = 1'b0;
      bus.fetch_valid = 1'b1;
      bus.fetch_addr  = 32'h10;
      wait_fetch_ready();
      @(posedge clk); #1;
      bus.fetch_valid = 1'b0;
      chk("pre_rst_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("pre_rst_data", bus.rsp_data, 32'hDEADBEAA);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("async_rst_data", bus.rsp_data, 32'h0);
      chk("async_rst_busy", {31'd0, bus.init_busy}, 32'd1);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      count_init("reinit");
      do_fetch(32'h10, 32'h0, 1'b0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
